// File: rtl/rfid_spi_responder_pkg.sv
// Shared types and constants for the MFRC522-style SPI register responder.
// Register map constants follow the MFRC522 datasheet addresses.
package rfid_pkg;

  localparam int RFID_ADDR_W = 6;
  localparam int RFID_DATA_W = 8;
  localparam int RFID_NREGS  = 1 << RFID_ADDR_W;

  localparam logic [RFID_ADDR_W-1:0] RFID_VERSION_ADDR = 6'h37;
  localparam logic [RFID_DATA_W-1:0] RFID_VERSION_VAL  = 8'h92;

  localparam logic [RFID_ADDR_W-1:0] REG_COMMAND    = 6'h01;
  localparam logic [RFID_ADDR_W-1:0] REG_FIFO_DATA  = 6'h09;
  localparam logic [RFID_ADDR_W-1:0] REG_FIFO_LEVEL = 6'h0A;
  localparam logic [RFID_ADDR_W-1:0] REG_VERSION    = 6'h37;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_WR,
    S_RD
  } rfid_state_e;

  // Address byte layout: {rw, addr[5:0], x}
  function automatic logic [RFID_ADDR_W-1:0] addr_of(
    input logic [RFID_DATA_W-1:0] b
  );
    return b[6:1];
  endfunction

endpackage

// File: rtl/rfid_spi_responder_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
// RST_VAL lets SS_n come out of reset without a spurious falling edge.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/rfid_spi_responder.sv
// SPI mode-0 slave with a 64x8 register file and MFRC522 addressing.
// Host port gives the bench/card model direct register access.
module rfid_spi_responder
  import rfid_pkg::*;
#(
  parameter int                     SYNC_STAGES  = 2,
  parameter logic [RFID_ADDR_W-1:0] VERSION_ADDR = RFID_VERSION_ADDR,
  parameter logic [7:0]             VERSION_VAL  = RFID_VERSION_VAL
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic                   spi_SCLK,
  input  logic                   spi_SS_n,
  input  logic                   spi_MOSI,
  output logic                   spi_MISO,
  input  logic [RFID_ADDR_W-1:0] host_addr,
  input  logic                   host_we,
  input  logic [7:0]             host_wdata,
  output logic [7:0]             host_rdata,
  output logic                   spi_wr_valid,
  output logic [RFID_ADDR_W-1:0] spi_wr_addr,
  output logic [7:0]             spi_wr_data,
  output logic                   spi_rd_valid,
  output logic [RFID_ADDR_W-1:0] spi_rd_addr
);

  logic w_sclk_q;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_ss_q;
  logic w_ss_rise;
  logic w_ss_fall;
  logic w_mosi;
  logic w_unused;

  logic [SYNC_STAGES-1:0] r_mosi_sync;

  rfid_state_e r_state;
  rfid_state_e w_state_nxt;

  logic [2:0]             r_bitcnt;
  logic [6:0]             r_rx;
  logic [RFID_ADDR_W-1:0] r_addr;
  logic [7:0]             r_tx;
  logic                   r_miso;
  logic                   r_wr_valid;
  logic [RFID_ADDR_W-1:0] r_wr_addr;
  logic [7:0]             r_wr_data;
  logic                   r_rd_valid;
  logic [RFID_ADDR_W-1:0] r_rd_addr;
  logic [7:0]             r_host_rdata;
  logic [7:0]             r_regs [0:RFID_NREGS-1];

  logic [7:0]             w_byte;
  logic                   w_byte_done;
  logic                   w_wr_en;
  logic                   w_ld_en;
  logic                   w_addr_en;
  logic [RFID_ADDR_W-1:0] w_ld_addr;

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk (
    .i_clk  (clk_clk),
    .i_rst  (reset_reset),
    .i_d    (spi_SCLK),
    .o_q    (w_sclk_q),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // SS_n resets low so a select held across reset never looks like a new fall
  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_ss (
    .i_clk  (clk_clk),
    .i_rst  (reset_reset),
    .i_d    (spi_SS_n),
    .o_q    (w_ss_q),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_MOSI};
    end
  end

  assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
  assign w_unused = &{1'b0, w_sclk_q, w_ss_rise};

  always_comb begin
    w_state_nxt = r_state;
    w_byte      = {r_rx, w_mosi};
    w_byte_done = w_sclk_rise && (r_bitcnt == 3'd7);
    w_wr_en     = 1'b0;
    w_ld_en     = 1'b0;
    w_addr_en   = 1'b0;
    w_ld_addr   = addr_of(w_byte);
    if (w_ss_q) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_ss_fall) w_state_nxt = S_ADDR;
        end
        S_ADDR: begin
          if (w_byte_done) begin
            w_state_nxt = w_byte[7] ? S_RD : S_WR;
            w_addr_en   = 1'b1;
            w_ld_en     = w_byte[7];
          end
        end
        S_WR: begin
          w_wr_en = w_byte_done;
        end
        S_RD: begin
          w_addr_en = w_byte_done;
          w_ld_en   = w_byte_done;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_bitcnt   <= '0;
      r_rx       <= '0;
      r_addr     <= '0;
      r_tx       <= '0;
      r_miso     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      r_wr_valid <= w_wr_en;
      r_rd_valid <= w_ld_en;
      if (r_state == S_IDLE || w_state_nxt == S_IDLE) begin
        r_bitcnt <= '0;
        r_rx     <= '0;
      end else if (w_sclk_rise) begin
        r_bitcnt <= r_bitcnt + 3'd1;
        r_rx     <= w_byte[6:0];
      end
      if (w_addr_en) begin
        r_addr <= w_ld_addr;
      end
      if (w_wr_en) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_byte;
      end
      if (w_ld_en) begin
        r_rd_addr <= w_ld_addr;
        r_tx      <= r_regs[w_ld_addr];
      end else if (w_sclk_fall && r_state == S_RD) begin
        r_tx <= {r_tx[6:0], 1'b0};
      end
      if (w_state_nxt == S_IDLE) begin
        r_miso <= 1'b0;
      end else if (w_sclk_fall) begin
        r_miso <= (r_state == S_RD) ? r_tx[7] : 1'b0;
      end
    end
  end

  // SPI write is applied after the host write so it wins on a collision
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < RFID_NREGS; i++) begin
        r_regs[i[RFID_ADDR_W-1:0]] <=
          (i[RFID_ADDR_W-1:0] == VERSION_ADDR) ? VERSION_VAL : 8'h00;
      end
      r_host_rdata <= '0;
    end else begin
      if (host_we && host_addr != VERSION_ADDR) begin
        r_regs[host_addr] <= host_wdata;
      end
      if (w_wr_en && r_addr != VERSION_ADDR) begin
        r_regs[r_addr] <= w_byte;
      end
      r_host_rdata <= r_regs[host_addr];
    end
  end

  assign spi_MISO     = r_miso;
  assign host_rdata   = r_host_rdata;
  assign spi_wr_valid = r_wr_valid;
  assign spi_wr_addr  = r_wr_addr;
  assign spi_wr_data  = r_wr_data;
  assign spi_rd_valid = r_rd_valid;
  assign spi_rd_addr  = r_rd_addr;

endmodule

// File: tb/tb_rfid_spi_responder.sv
// Bench for rfid_spi_responder: directed vector table, abort/reset
// sequences and random transactions against a register-map model.
module tb_rfid_spi_responder;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [5:0] haddr;
  logic       hwe;
  logic [7:0] hwdata;
  logic [7:0] hrdata;
  logic       wr_v;
  logic [5:0] wr_a;
  logic [7:0] wr_d;
  logic       rd_v;
  logic [5:0] rd_a;

  always #5 clk = ~clk;

  rfid_spi_responder dut (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .spi_SCLK     (sclk),
    .spi_SS_n     (ss_n),
    .spi_MOSI     (mosi),
    .spi_MISO     (miso),
    .host_addr    (haddr),
    .host_we      (hwe),
    .host_wdata   (hwdata),
    .host_rdata   (hrdata),
    .spi_wr_valid (wr_v),
    .spi_wr_addr  (wr_a),
    .spi_wr_data  (wr_d),
    .spi_rd_valid (rd_v),
    .spi_rd_addr  (rd_a)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  mregs [64];
  logic [13:0] wr_q [$];
  logic [13:0] ewr_q [$];
  logic [5:0]  rd_q [$];
  logic [5:0]  erd_q [$];

  always @(negedge clk) begin
    if (wr_v) wr_q.push_back({wr_a, wr_d});
    if (rd_v) rd_q.push_back(rd_a);
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    return w[31-8*k -: 8];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mregs[i] = 8'h00;
    mregs[6'h37] = 8'h92;
  endtask

  // Register-map view of a transaction: reads return regs at the
  // currently addressed location, writes repeat at one address.
  task automatic model_txn(input int nb, input logic [31:0] m,
                           output logic [31:0] er);
    logic [7:0] b0;
    logic [5:0] a;
    b0 = byte_of(m, 0);
    a  = b0[6:1];
    er = 32'h0;
    ewr_q.delete();
    erd_q.delete();
    for (int k = 1; k < nb; k++) begin
      logic [7:0] bk;
      bk = byte_of(m, k);
      if (b0[7]) begin
        er[31-8*k -: 8] = mregs[a];
        erd_q.push_back(a);
        a = bk[6:1];
      end else begin
        ewr_q.push_back({a, bk});
        if (a != 6'h37) mregs[a] = bk;
      end
    end
    if (b0[7]) erd_q.push_back(a);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nb,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nb; i++) begin
      mosi = b[7-i];
      wclk(HALF);
      rx   = {rx[6:0], miso};
      sclk = 1'b1;
      wclk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_txn(input int nb, input logic [31:0] m,
                         output logic [31:0] r);
    logic [7:0] rb;
    r = 32'h0;
    wr_q.delete();
    rd_q.delete();
    ss_n = 1'b0;
    wclk(6);
    for (int k = 0; k < nb; k++) begin
      spi_bits(byte_of(m, k), 8, rb);
      r[31-8*k -: 8] = rb;
    end
    wclk(6);
    ss_n = 1'b1;
    wclk(10);
  endtask

  task automatic check_events(input string tag);
    int nw;
    int nr;
    chk({tag, "_wr_cnt"}, 32'(wr_q.size()), 32'(ewr_q.size()));
    chk({tag, "_rd_cnt"}, 32'(rd_q.size()), 32'(erd_q.size()));
    nw = (wr_q.size() < ewr_q.size()) ? wr_q.size() : ewr_q.size();
    nr = (rd_q.size() < erd_q.size()) ? rd_q.size() : erd_q.size();
    for (int i = 0; i < nw; i++)
      chk($sformatf("%s_wr%0d", tag, i), 32'(wr_q[i]), 32'(ewr_q[i]));
    for (int i = 0; i < nr; i++)
      chk($sformatf("%s_rd%0d", tag, i), 32'(rd_q[i]), 32'(erd_q[i]));
  endtask

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    haddr  = a;
    hwdata = d;
    hwe    = 1'b1;
    wclk(1);
    hwe    = 1'b0;
    if (a != 6'h37) mregs[a] = d;
  endtask

  task automatic host_read_chk(input logic [5:0] a);
    haddr = a;
    wclk(2);
    chk($sformatf("host_rd_%02h", a), 32'(hrdata), 32'(mregs[a]));
  endtask

  task automatic run_txn(input string tag, input int nb,
                         input logic [31:0] m, input logic [31:0] exp_miso,
                         input logic use_exp);
    logic [31:0] r;
    logic [31:0] er;
    spi_txn(nb, m, r);
    model_txn(nb, m, er);
    chk({tag, "_miso"}, r, use_exp ? exp_miso : er);
    check_events(tag);
  endtask

  typedef struct packed {
    logic [2:0]  nb;
    logic [31:0] mosi;
    logic [31:0] miso;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [7:0]  rb;
    logic [31:0] m;
    int          nb;

    tbl[0] = '{3'd2, 32'hEE00_0000, 32'h0092_0000};
    tbl[1] = '{3'd2, 32'h020C_0000, 32'h0000_0000};
    tbl[2] = '{3'd3, 32'h9294_0000, 32'h00A5_3C00};
    tbl[3] = '{3'd4, 32'h1211_2233, 32'h0000_0000};
    tbl[4] = '{3'd2, 32'h9200_0000, 32'h0033_0000};
    tbl[5] = '{3'd2, 32'h8200_0000, 32'h000C_0000};
    tbl[6] = '{3'd2, 32'h6E55_0000, 32'h0000_0000};
    tbl[7] = '{3'd2, 32'hEE00_0000, 32'h0092_0000};

    rst    = 1'b1;
    sclk   = 1'b0;
    ss_n   = 1'b1;
    mosi   = 1'b0;
    hwe    = 1'b0;
    haddr  = 6'h00;
    hwdata = 8'h00;
    model_reset();
    wclk(4);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_wr_v", 32'(wr_v), 32'h0);
    chk("rst_rd_v", 32'(rd_v), 32'h0);
    chk("rst_hrdata", 32'(hrdata), 32'h0);
    rst = 1'b0;
    wclk(4);
    host_read_chk(6'h37);
    host_read_chk(6'h01);

    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        host_write(6'h09, 8'hA5);
        host_write(6'h0A, 8'h3C);
      end
      run_txn($sformatf("vec%0d", i), int'(tbl[i].nb), tbl[i].mosi,
              tbl[i].miso, 1'b1);
    end
    haddr = 6'h01;
    wclk(2);
    chk("vec_reg01", 32'(hrdata), 32'h0C);
    haddr = 6'h09;
    wclk(2);
    chk("vec_reg09", 32'(hrdata), 32'h33);

    // Write aborted after 4 data bits
    wr_q.delete();
    rd_q.delete();
    ss_n = 1'b0;
    wclk(6);
    spi_bits(8'h12, 8, rb);
    spi_bits(8'hAB, 4, rb);
    ss_n = 1'b1;
    wclk(10);
    chk("abort_wr_cnt", 32'(wr_q.size()), 32'h0);
    chk("abort_miso", 32'(rb), 32'h0);
    chk("abort_miso_idle", 32'(miso), 32'h0);
    host_read_chk(6'h09);
    run_txn("post_abort", 2, 32'h9200_0000, 32'h0, 1'b0);

    // Reset in the middle of a version read with SS_n held low
    wr_q.delete();
    rd_q.delete();
    ss_n = 1'b0;
    wclk(6);
    spi_bits(8'hEE, 8, rb);
    spi_bits(8'h00, 3, rb);
    chk("midrd_bits", 32'(rb), 32'h04);
    wclk(6);
    chk("midrd_miso", 32'(miso), 32'h1);
    rst = 1'b1;
    wclk(1);
    chk("midrd_rst_miso", 32'(miso), 32'h0);
    wclk(1);
    rst = 1'b0;
    model_reset();
    wclk(2);
    wr_q.delete();
    rd_q.delete();
    spi_bits(8'hFF, 8, rb);
    spi_bits(8'h00, 8, rb);
    chk("held_low_miso", 32'(rb), 32'h0);
    chk("held_low_rd_cnt", 32'(rd_q.size()), 32'h0);
    chk("held_low_wr_cnt", 32'(wr_q.size()), 32'h0);
    ss_n = 1'b1;
    wclk(10);
    host_read_chk(6'h37);
    host_read_chk(6'h01);
    host_read_chk(6'h09);
    host_read_chk(6'h0A);
    run_txn("post_rst", 2, 32'hEE00_0000, 32'h0092_0000, 1'b1);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0)
        host_write(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
      nb = int'($urandom_range(2, 4));
      m  = $urandom();
      run_txn($sformatf("rnd%0d", t), nb, m, 32'h0, 1'b0);
      host_read_chk(6'($urandom_range(0, 63)));
    end

    for (int a = 0; a < 64; a++) host_read_chk(6'(a));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rfid_spi_responder.md
# rfid_spi_responder

SPI slave emulating the MFRC522 register-access protocol: the far end of the `rfid_spi_*` master port. It holds a 64×8 register file that the SPI master reads and writes, plus a host-side port for the bench or a behavioural card model. It is used in system simulation and in loop-back hardware tests, wired directly to `rfid_spi_SCLK/MOSI/SS_n/MISO`.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on SCLK, MOSI and SS_n (≥2).
- `VERSION_ADDR`, default 6'h37: address of the read-only version register.
- `VERSION_VAL`, default 8'h92: value of the version register; it ignores all writes.
- `clk_clk`  in  1  system clock; all logic on its rising edge.
- `reset_reset`  in  1  synchronous, active-high reset.
- `spi_SCLK`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to `clk_clk`.
- `spi_SS_n`  in  1  active-low select, asynchronous.
- `spi_MOSI`  in  1  master data, MSB first.
- `spi_MISO`  out  1  slave data, MSB first; 0 when deselected.
- `host_addr`  in  6  host register address.
- `host_we`  in  1  host write strobe.
- `host_wdata`  in  8  host write data.
- `host_rdata`  out  8  contents of `host_addr`, registered (1-cycle latency).
- `spi_wr_valid`  out  1  one-cycle pulse for each register byte written over SPI.
- `spi_wr_addr`  out  6  address for `spi_wr_valid`.
- `spi_wr_data`  out  8  data for `spi_wr_valid`.
- `spi_rd_valid`  out  1  one-cycle pulse for each register byte loaded for SPI readout. A model uses it to pop the FIFODataReg.
- `spi_rd_addr`  out  6  address for `spi_rd_valid`.

## Operation
- **Inputs:** SCLK, SS_n and MOSI pass through `SYNC_STAGES` flops. Rising and falling edges of SCLK are detected on the synchronized signal.
- **Shift rules:** MOSI is sampled on the SCLK rise. MISO updates on the SCLK fall. A bit counter (3 bits) wraps every 8 rises.
- **Address byte:** `{rw, addr[5:0], x}`. `rw`=1 means read; bit 0 is ignored.
- **States:** IDLE, ADDR, WR, RD.
  - IDLE → ADDR on synchronized SS_n falling.
  - ADDR → RD or WR after the 8th rise, per `rw`. The address is latched.
  - WR: each completed byte writes `regs[addr]`. The address does not increment, matching FIFO-style repeated writes. `spi_wr_valid` pulses.
  - RD: at ADDR completion, and at each completed RD byte, `regs[addr]` loads the TX shifter and `spi_rd_valid` pulses. Each completed RD-phase MOSI byte supplies the next address from its bits 6:1. The final byte's address is still loaded and pulsed.
  - Any state → IDLE on SS_n high. A partial byte is discarded with no write and no pulse.
- **MISO:** outputs 0 during the ADDR byte and in IDLE. In RD, bit 7 of the loaded byte appears after the 8th fall of the preceding byte, then shifts on each fall.
- **Host port:** a host write to any address except `VERSION_ADDR` updates the register. If an SPI write and a host write hit the same address in the same cycle, the SPI write wins.
- **Reset:** all registers clear to 0x00 except `VERSION_ADDR`=`VERSION_VAL`. State goes to IDLE, counters clear, MISO=0, pulses=0, `host_rdata`=0. Reset mid-transaction aborts it; the responder waits for a fresh SS_n fall, not the current low level.

## Timing
- Edge-detect latency is `SYNC_STAGES`+1 clocks from the pin.
- SCLK high and low phases must each be ≥ `SYNC_STAGES`+3 clocks. With the defaults, SCLK ≤ `clk_clk`/10.
- Register write lands 1 clock after the 8th rise is detected. `spi_wr_valid` is in that same cycle.
- TX load occurs on the same detected rise. MISO is valid ≤ `SYNC_STAGES`+2 clocks after the pin SCLK fall.
- SS_n fall to first SCLK rise must be ≥ `SYNC_STAGES`+2 clocks.

## Structure
- Shared package `rfid_pkg`:
  - state enum
  - `RFID_ADDR_W`=6
  - `VERSION_ADDR` default
  - register address constants: CommandReg 0x01, FIFODataReg 0x09, FIFOLevelReg 0x0A, VersionReg 0x37
- Sub-module `spi_sync_edge`: synchronizer plus rise/fall detector, instantiated for SCLK and SS_n. MOSI uses the synchronizer only.

## Test plan
- After reset, master reads 0x37 (MOSI 0xEE, 0x00) → MISO byte 2 = 0x92, `spi_rd_valid` pulse with addr 0x37.
- Master writes 0x01←0x0C (MOSI 0x02, 0x0C) → `spi_wr_valid` with addr 0x01, data 0x0C; `host_rdata` at addr 0x01 = 0x0C.
- Burst read: MOSI 0x92, 0x94, 0x00 with host preloaded regs 0x09=0xA5, 0x0A=0x3C → MISO bytes 2 and 3 = 0xA5, 0x3C.
- Repeated write: MOSI 0x12, 0x11, 0x22, 0x33 → three `spi_wr_valid` pulses to 0x09; final reg value 0x33.
- SS_n raised after 4 bits of a write data byte → no write, no pulse, MISO=0. Next transaction decodes correctly.
- `reset_reset` mid-read → MISO=0 immediately, reg 0x37=0x92, all others 0x00. Held-low SS_n is not treated as a new start.
